// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, SPI mode constants and default word width
package spi_pkg;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
  localparam int DATA_WIDTH_DEF = 8;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall detect on the synchronized level
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rst_val,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{i_rst_val}};
      r_dly  <= i_rst_val;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_dly;
  assign o_fall = ~r_sync[SYNC_STAGES-1] & r_dly;
endmodule

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: oversampled SPI responder, all four modes, MSB-first, back-to-back words
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int data_width  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic [data_width-1:0] s_din,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [data_width-1:0] s_dout,
  output logic                  done_tick,
  output logic                  abort_tick,
  output logic                  busy
);
  localparam int CW = $clog2(data_width);
  state_t                 r_state, w_next;
  logic [1:0]             r_mode;
  logic [data_width-1:0]  r_tx_sr, r_rx_sr;
  logic [CW-1:0]          r_bit_cnt;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall, w_mosi;
  logic w_active, w_cpol, w_cpha, w_lead, w_trail, w_sample, w_shift, w_done, w_abort, w_start;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst_n(rst_n), .i_rst_val(CPOL), .i_d(sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
    .clk(clk), .rst_n(rst_n), .i_rst_val(1'b1), .i_d(ss_n), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
  assign w_active = r_state == ACTIVE;
  assign w_start  = !w_active && w_ss_fall;
  assign w_cpol   = r_mode inside {MODE2, MODE3};
  assign w_cpha   = r_mode inside {MODE1, MODE3};
  assign w_lead   = w_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail  = w_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample = w_active && (w_cpha ? w_trail : w_lead);
  // bit_cnt==0 on a shift edge means a freshly loaded word whose MSB must stay on miso
  assign w_shift  = w_active && (w_cpha ? w_lead : w_trail) && r_bit_cnt != '0;
  assign w_done   = w_sample && r_bit_cnt == CW'(data_width - 1);
  assign w_abort  = w_active && w_ss_rise && r_bit_cnt != '0 && !w_done;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb w_next = w_active ? (w_ss_rise ? IDLE : ACTIVE) : (w_ss_fall ? ACTIVE : IDLE);

  always_comb begin
    busy    = w_active;
    miso_oe = w_active;
    miso    = w_active & r_tx_sr[data_width-1];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mosi_sync <= '0;
      r_mode      <= MODE0;
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
      r_bit_cnt   <= '0;
      s_dout      <= '0;
      done_tick   <= 1'b0;
      abort_tick  <= 1'b0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      done_tick   <= w_done;
      abort_tick  <= w_abort;
      if (w_start) begin
        r_mode    <= {CPOL, CPHA};
        r_tx_sr   <= s_din;
        r_rx_sr   <= '0;
        r_bit_cnt <= '0;
      end else begin
        if (w_sample) begin
          r_rx_sr   <= {r_rx_sr[data_width-2:0], w_mosi};
          r_bit_cnt <= w_done ? '0 : r_bit_cnt + 1'b1;
        end
        if (w_done) begin
          s_dout  <= {r_rx_sr[data_width-2:0], w_mosi};
          r_tx_sr <= s_din;
        end else if (w_shift) r_tx_sr <= r_tx_sr << 1;
      end
    end
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: directed SPI master with a done/abort scoreboard monitor
module tb_spi_slave_sync;
  localparam int DW = 8;
  logic clk = 0, rst_n = 0, cpol = 0, cpha = 0, sclk = 0, ss_n = 1, mosi = 0;
  logic [DW-1:0] s_din = 8'hAB;
  logic miso, miso_oe, done_tick, abort_tick, busy;
  logic [DW-1:0] s_dout, e;
  logic [15:0] rx;
  logic [DW-1:0] exp_q[$];
  int n_abort_exp = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  spi_slave_sync #(.data_width(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .CPOL(cpol), .CPHA(cpha), .s_din(s_din),
    .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .s_dout(s_dout), .done_tick(done_tick), .abort_tick(abort_tick), .busy(busy)
  );

  always @(negedge clk) begin
    if (done_tick) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_tick unexpected, s_dout=%0h required no pulse", s_dout);
      end else begin
        e = exp_q.pop_front();
        if (s_dout !== e) begin
          errors++;
          $display("FAIL s_dout actual=%0h required=%0h", s_dout, e);
        end
      end
    end
    if (abort_tick) begin
      checks++;
      if (n_abort_exp == 0) begin
        errors++;
        $display("FAIL abort_tick unexpected actual=1 required=0");
      end else n_abort_exp--;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " s_dout"}, 16'(s_dout), 16'h0);
    chk({nm, " done_tick"}, 16'(done_tick), 16'h0);
    chk({nm, " abort_tick"}, 16'(abort_tick), 16'h0);
    chk({nm, " busy"}, 16'(busy), 16'h0);
    chk({nm, " miso"}, 16'(miso), 16'h0);
    chk({nm, " miso_oe"}, 16'(miso_oe), 16'h0);
  endtask

  task automatic rst_pulse();
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  // evt: 1 = change s_din to 3C, 2 = toggle DUT CPOL input; applied before bit evt_bit
  task automatic xfer(input logic mc, input logic mh, input int nbits, input logic [15:0] tx,
                      input int evt_bit, input int evt, input bit end_frame, output logic [15:0] r);
    r = '0;
    sclk = mc;
    ss_n = 0;
    repeat (8) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (nbits - 1 - i == evt_bit) begin
        if (evt == 1) s_din = 8'h3C;
        else if (evt == 2) cpol = ~cpol;
      end
      if (!mh) begin
        mosi = tx[i];
        half();
        sclk = ~mc;
        r = {r[14:0], miso};
        half();
        sclk = mc;
      end else begin
        half();
        sclk = ~mc;
        mosi = tx[i];
        half();
        sclk = mc;
        r = {r[14:0], miso};
      end
    end
    if (end_frame) begin
      half();
      ss_n = 1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic frame_mode(input logic mc, input logic mh, input string nm);
    cpol = mc;
    cpha = mh;
    sclk = mc;
    s_din = 8'hAB;
    rst_pulse();
    exp_q.push_back(8'h66);
    xfer(mc, mh, 8, 16'h0066, -1, 0, 1, rx);
    chk({nm, " master rx"}, rx, 16'h00AB);
    chk({nm, " s_dout"}, 16'(s_dout), 16'h0066);
    chk({nm, " busy idle"}, 16'(busy), 16'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("init");
    rst_n = 1;
    repeat (2) @(negedge clk);
    frame_mode(0, 0, "mode0");
    frame_mode(0, 1, "mode1");
    frame_mode(1, 0, "mode2");
    frame_mode(1, 1, "mode3");

    cpol = 0; cpha = 0; sclk = 0; s_din = 8'hAB;
    rst_pulse();
    exp_q.push_back(8'h66);
    exp_q.push_back(8'h5A);
    xfer(0, 0, 16, 16'h665A, 1, 1, 1, rx);
    chk("b2b master rx", rx, 16'hAB3C);
    chk("b2b s_dout", 16'(s_dout), 16'h005A);

    n_abort_exp = 1;
    xfer(0, 0, 5, 16'h000C, -1, 0, 0, rx);
    ss_n = 1;
    repeat (3) @(negedge clk);
    chk("abort busy", 16'(busy), 16'h0);
    chk("abort miso_oe", 16'(miso_oe), 16'h0);
    repeat (5) @(negedge clk);
    chk("abort pulses pending", 16'(n_abort_exp), 16'h0);
    chk("abort s_dout kept", 16'(s_dout), 16'h005A);

    s_din = 8'hAB;
    xfer(0, 0, 3, 16'h0003, -1, 0, 0, rx);
    #1 rst_n = 0;
    #1 chk_zero("async reset");
    ss_n = 1;
    sclk = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h66);
    xfer(0, 0, 8, 16'h0066, -1, 0, 1, rx);
    chk("post-reset master rx", rx, 16'h00AB);
    chk("post-reset s_dout", 16'(s_dout), 16'h0066);

    exp_q.push_back(8'h66);
    xfer(0, 0, 8, 16'h0066, 3, 2, 1, rx);
    chk("cpol toggle master rx", rx, 16'h00AB);
    chk("cpol toggle s_dout", 16'(s_dout), 16'h0066);
    sclk = 1;
    repeat (8) @(negedge clk);
    exp_q.push_back(8'h66);
    xfer(1, 0, 8, 16'h0066, -1, 0, 1, rx);
    chk("new mode master rx", rx, 16'h00AB);

    repeat (5) @(negedge clk);
    chk("done_tick missing", 16'(exp_q.size()), 16'h0);
    chk("abort_tick missing", 16'(n_abort_exp), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
